uart_tx_arbiter: RTL

- Shares one UART transmitter between NUM_REQ byte-stream requesters, e.g. the keyboard scanner, debug reporter and echo path.
- Sequences the UART's dataInTxValid / dataInTxBusy handshake: one-cycle valid, wait for busy to rise, wait for busy to fall.
- Round-robin arbitration with message locking: a requester keeps the grant until it sends a byte flagged last, so multi-byte messages are never interleaved.

---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter, with message locking until a byte flagged last.
// Define UART_ARB_LOCK_TIMEOUT_EN to drop a lock whose owner stays idle for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_WAIT    = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [8*NUM_REQ-1:0]   reqData,
  input  logic [NUM_REQ-1:0]     reqLast,
  output logic [NUM_REQ-1:0]     reqReady,
  output logic [7:0]             txData,
  output logic                   txValid,
  input  logic                   txBusy,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   locked,
  output logic                   busyTimeout,
  output logic                   lockDropped
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW_W  = $clog2(BUSY_WAIT + 1);

  if (NUM_REQ < 1 || NUM_REQ > 8 || BUSY_WAIT < 1 || LOCK_TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 locked_q, locked_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic                 busy_to_q, busy_to_d;
  logic [BW_W-1:0]      busy_cnt_q, busy_cnt_d;

  logic [IDX_W-1:0]     cand;
  logic                 cand_found;
  logic [NUM_REQ-1:0]   cand_onehot;
  logic                 accept;
  logic                 lock_timeout_hit;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  // A lock restricts the candidate to the owner; otherwise search upward from the pointer with wrap.
  always_comb begin
    int idx;
    idx        = 0;
    cand       = '0;
    cand_found = 1'b0;
    if (locked_q) begin
      cand       = owner_q;
      cand_found = reqValid[owner_q];
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!cand_found && reqValid[idx]) begin
          cand_found = 1'b1;
          cand       = IDX_W'(idx);
        end
      end
    end
  end

  always_comb begin
    cand_onehot       = '0;
    cand_onehot[cand] = 1'b1;
  end

  assign accept   = (state_q == IDLE) && cand_found && !txBusy;
  assign reqReady = accept ? cand_onehot : '0;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
    locked_d   = locked_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    busy_to_d  = busy_to_q;
    busy_cnt_d = busy_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_data_d = reqData[int'(cand)*8 +: 8];
          grant_d   = cand_onehot;
          state_d   = SEND;
          if (reqLast[cand]) begin
            locked_d = 1'b0;
            ptr_d    = next_idx(cand);
          end else begin
            locked_d = 1'b1;
            owner_d  = cand;
          end
        end else if (lock_timeout_hit) begin
          locked_d = 1'b0;
          ptr_d    = next_idx(owner_q);
        end
      end
      SEND: begin
        state_d    = WAIT_BUSY;
        busy_cnt_d = '0;
      end
      // A UART that never raises busy must not wedge the arbiter; flag it and move on.
      WAIT_BUSY: begin
        if (txBusy) begin
          state_d = WAIT_DONE;
        end else if (int'(busy_cnt_q) >= BUSY_WAIT - 1) begin
          busy_to_d = 1'b1;
          state_d   = IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q + BW_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!txBusy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      grant_q    <= '0;
      locked_q   <= 1'b0;
      owner_q    <= '0;
      ptr_q      <= '0;
      busy_to_q  <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
      locked_q   <= locked_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      busy_to_q  <= busy_to_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
  localparam int LT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [LT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            lock_drop_q, lock_drop_d;

  // Counts idle cycles of a locked owner; any accept or unlocked state restarts it.
  always_comb begin
    lock_cnt_d       = lock_cnt_q;
    lock_timeout_hit = 1'b0;
    if (accept || !locked_q) begin
      lock_cnt_d = '0;
    end else if (state_q == IDLE && !reqValid[owner_q]) begin
      if (int'(lock_cnt_q) >= LOCK_TIMEOUT - 1) begin
        lock_timeout_hit = 1'b1;
        lock_cnt_d       = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + LT_W'(1);
      end
    end
    lock_drop_d = lock_timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q  <= '0;
      lock_drop_q <= 1'b0;
    end else begin
      lock_cnt_q  <= lock_cnt_d;
      lock_drop_q <= lock_drop_d;
    end
  end

  assign lockDropped = lock_drop_q;
`else
  assign lock_timeout_hit = 1'b0;
  assign lockDropped      = 1'b0;
`endif

  assign txValid     = (state_q == SEND);
  assign txData      = tx_data_q;
  assign grant       = grant_q;
  assign locked      = locked_q;
  assign busyTimeout = busy_to_q;

endmodule
